// File: rtl/regbank_wr_demux16.sv
// Write-side register bank for the 16 x 32-bit ARM datapath read mux: one staging entry,
// one-hot commit strobe, R15 +4 increment. Define REGBANK_BYPASS_EN to forward the staged write.
module regbank_wr_demux16 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [3:0]   wr_sel,
    input  logic [31:0]  wr_data,
    input  logic         hold,
    input  logic         pc_inc,
    output logic [511:0] q_flat,
    output logic [15:0]  wr_onehot,
    output logic         pend_valid
);

    logic [31:0] regs [16];
    logic [3:0]  pend_sel;
    logic [31:0] pend_data;
    logic        accept;
    logic        commit;

    // The stage frees up on any commit edge, so a new request can ride along with it.
    assign wr_ready = !pend_valid || !hold;
    assign accept   = wr_valid && wr_ready;
    assign commit   = pend_valid && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_sel   <= 4'd0;
            pend_data  <= 32'd0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_sel   <= wr_sel;
            pend_data  <= wr_data;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_onehot <= 16'd0;
        end else begin
            wr_onehot <= commit ? (16'd1 << pend_sel) : 16'd0;
        end
    end

    // The commit is assigned last so it overrides a same-edge PC increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            if (pc_inc) begin
                regs[15] <= regs[15] + 32'd4;
            end
            if (commit) begin
                regs[pend_sel] <= pend_data;
            end
        end
    end

    always_comb begin
        q_flat = '0;
        for (int i = 0; i < 16; i++) begin
            q_flat[i*32 +: 32] = regs[i];
`ifdef REGBANK_BYPASS_EN
            if (pend_valid && pend_sel == 4'(i)) begin
                q_flat[i*32 +: 32] = pend_data;
            end
`endif
        end
    end

endmodule

// File: doc/regbank_wr_demux16.md
# regbank_wr_demux16

Write-side companion to the 16-input, 32-bit read multiplexer in the ARM datapath: accepts register write requests over a valid/ready handshake, decodes the 4-bit destination into a one-hot strobe and commits the data into a 16 x 32-bit register bank. The bank is exported as a flat 512-bit bus that feeds the read multiplexers' 16 data inputs, R0 at bits 31:0 through R15 at bits 511:480. R15 (PC) additionally supports a +4 auto-increment.

## Interface
- No parameters: data width 32 and depth 16 are fixed to match the read multiplexer.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `wr_valid`  in  1  write request present
- `wr_ready`  out  1  request accepted when `wr_valid && wr_ready` at a rising edge
- `wr_sel`  in  4  destination register index, 0..15
- `wr_data`  in  32  write data
- `hold`  in  1  stall; blocks the commit of the pending write
- `pc_inc`  in  1  increment R15 by 4 this cycle
- `q_flat`  out  512  register bank; R*n* at bits [32n+31:32n]
- `wr_onehot`  out  16  registered one-hot strobe of the register committed on the last edge, otherwise 0
- `pend_valid`  out  1  a staged write is waiting to commit

## Operation
- The block has one staging entry: `pend_valid`, `pend_sel[3:0]`, `pend_data[31:0]`.
- `wr_ready = !pend_valid || !hold`, a combinational function of state and `hold` only; it is never a function of `wr_valid`.
- **Accept:** on a handshake, `pend_sel <= wr_sel`, `pend_data <= wr_data`, `pend_valid <= 1`.
- **Commit:** on an edge with `pend_valid && !hold`:
  - R[`pend_sel`] <= `pend_data`.
  - `wr_onehot <= 16'b1 << pend_sel`.
  - `pend_valid` is cleared, unless a new accept happens on the same edge.
- **Accept and commit on the same edge:** the old entry commits and the new entry is loaded. This gives back-to-back throughput of 1 write per cycle.
- **`wr_onehot` when no commit:** it is 0 on every edge without a commit. It is a one-cycle pulse per commit.
- **PC increment:** when `pc_inc=1`, R15 <= R15 + 32'd4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- **Collision:** if a commit to R15 and `pc_inc` happen on the same edge, the commit wins and the increment is dropped.
- **Hold with pending entry:** when `hold=1` and `pend_valid=1`, the entry is retained unchanged and `wr_ready=0`.
- **Hold with empty stage:** when `hold=1` and `pend_valid=0`, one request may still be accepted. It waits for `hold` to drop.
- `wr_sel` is always in range; there is no invalid index.

## Timing
- **Reset value of all outputs:** while `rst_n=0`, asynchronously:
  - all 16 registers are 0, so `q_flat=0`.
  - `pend_valid=0` and `wr_onehot=0`.
  - `wr_ready=1`, because `pend_valid=0`.
- **Reset release:** the block accepts on the first rising edge after `rst_n` rises.
- **Reset mid-operation:** a staged write is discarded and never committed.
- **Write latency** (without bypass), handshake on edge N:
  - the commit happens on edge N+1 if `hold=0` during the cycle after N;
  - the data is visible on `q_flat` after edge N+1;
  - `wr_onehot` is high for the cycle after N+1.
- **Held write:** each cycle `hold=1` delays the commit by one edge.
- **PC increment latency:** `pc_inc` sampled at edge N; the new R15 is visible after edge N.

## Configuration
- **`REGBANK_BYPASS_EN` defined:**
  - `q_flat` forwards combinationally: the slice for `pend_sel` shows `pend_data` whenever `pend_valid=1`, including while held.
  - The read latency from handshake is therefore 0 cycles after edge N.
  - If `pend_sel=15` and `pc_inc` is active, the forwarded `pend_data` is shown on the R15 slice.
  - The register update and `wr_onehot` timing are unchanged.
- **Not defined:** `q_flat` is driven purely from the registers, with no combinational path from the staging entry.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with `pend_valid=1` -> `q_flat=0`, `wr_onehot=0`, `pend_valid=0`, `wr_ready=1`; after release the discarded write never appears.
- **Single write:** write R3=32'hDEADBEEF with `hold=0` -> bits[127:96]=DEADBEEF one edge after the handshake; `wr_onehot=16'h0008` for exactly one cycle.
- **Streaming:** back-to-back writes R0..R15 with data = index*16'h1111 on 16 consecutive edges, `hold=0` -> `wr_ready` stays 1 throughout, 16 distinct one-hot pulses, final `q_flat` matches all 16 values.
- **Hold:** accept R7=5, then hold for 3 cycles while `wr_valid` stays high with R8=9 -> `wr_ready=0` during the hold, R7 and R8 unchanged; on release R7 commits and R8 is accepted on the same edge, and R8 commits on the next edge.
- **PC wrap and collision:** set R15=32'hFFFF_FFF8 and pulse `pc_inc` twice -> FFFF_FFFC then 0. A commit of R15=100 with `pc_inc=1` -> R15=100.
- **Bypass (`REGBANK_BYPASS_EN` only):** accept R2=32'h55 with `hold=1` -> bits[95:64]=55 immediately; the register commit happens only after `hold` drops.
